axi_tlb_cfg_sequencer: RTL

Serialises run-time reconfiguration of the AXI TLB's entry table and bypass flag. Before changing any entry or the bypass flag, it closes the TLB's AW/AR ingress and drains in-flight transactions, so no transaction can be translated by a half-updated table. It sits between a configuration master (CSR or mailbox) and the TLB's `entries_i`/`bypass_i` inputs. It observes the TLB slave-port handshakes through single-cycle pulses.

---
 rtl/axi_tlb_cfg_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_tlb_cfg_sequencer.sv
// Serialises TLB entry/bypass updates: gates AW/AR ingress, drains
// outstanding transactions, applies one update, then reports completion.
module axi_tlb_cfg_sequencer #(
   parameter int unsigned NumEntries    = 4,
   parameter int unsigned EntryWidth    = 64,
   parameter int unsigned MaxTxns       = 8,
   parameter int unsigned TimeoutCycles = 0,
   parameter logic        BypassRst     = 1'b1,
   localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1,
   localparam int unsigned CntW = $clog2(MaxTxns + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             upd_valid_i,
   output logic                             upd_ready_o,
   input  logic [1:0]                       upd_op_i,
   input  logic [IdxW-1:0]                  upd_idx_i,
   input  logic [EntryWidth-1:0]            upd_entry_i,
   output logic                             done_valid_o,
   input  logic                             done_ready_i,
   output logic                             done_err_o,
   input  logic                             aw_hs_i,
   input  logic                             b_hs_i,
   input  logic                             ar_hs_i,
   input  logic                             r_last_hs_i,
   output logic                             gate_o,
   output logic [NumEntries*EntryWidth-1:0] entries_o,
   output logic                             bypass_o,
   output logic [CntW-1:0]                  inflight_wr_o,
   output logic [CntW-1:0]                  inflight_rd_o,
   output logic                             cnt_err_o
);

   localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_APPLY,
      S_RESP
   } state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic [1:0]                       r_op;
   logic [IdxW-1:0]                  r_idx;
   logic [EntryWidth-1:0]            r_entry;
   logic [TW-1:0]                    r_tcnt;
   logic                             r_gate;
   logic                             r_err;
   logic                             r_bypass;
   logic                             r_cnt_err;
   logic [NumEntries*EntryWidth-1:0] r_entries;
   logic [CntW-1:0]                  r_wr;
   logic [CntW-1:0]                  r_rd;

   logic            w_accept;
   logic            w_bad;
   logic            w_drained;
   logic            w_timeout;
   logic [CntW-1:0] w_wr_nxt;
   logic [CntW-1:0] w_rd_nxt;
   logic            w_wr_err;
   logic            w_rd_err;

   // Saturating up/down step; MSB of the result flags an over/underflow.
   function automatic logic [CntW:0] f_step(
      input logic [CntW-1:0] c,
      input logic            inc,
      input logic            dec
   );
      logic [CntW:0] res;
      res = {1'b0, c};
      if (inc && !dec) begin
         if (c == CntW'(MaxTxns)) res[CntW] = 1'b1;
         else res[CntW-1:0] = c + 1'b1;
      end else if (dec && !inc) begin
         if (c == '0) res[CntW] = 1'b1;
         else res[CntW-1:0] = c - 1'b1;
      end
      return res;
   endfunction

   assign {w_wr_err, w_wr_nxt} = f_step(r_wr, aw_hs_i, b_hs_i);
   assign {w_rd_err, w_rd_nxt} = f_step(r_rd, ar_hs_i, r_last_hs_i);

   assign w_accept  = upd_valid_i && (r_state == S_IDLE);
   assign w_bad     = (upd_op_i == OP_ILL) ||
                      ((upd_op_i == OP_WR) && (32'(upd_idx_i) >= NumEntries));
   assign w_drained = (r_wr == '0) && (r_rd == '0);
   assign w_timeout = (TimeoutCycles != 0) &&
                      (32'(r_tcnt) == TimeoutCycles - 1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_bad ? S_RESP : S_DRAIN;
         S_DRAIN: begin
            if (w_drained)      w_state_nxt = S_APPLY;
            else if (w_timeout) w_state_nxt = S_RESP;
         end
         S_APPLY: w_state_nxt = S_RESP;
         S_RESP:  if (done_ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_gate  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gate  <= (w_state_nxt == S_DRAIN) || (w_state_nxt == S_APPLY);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_op      <= OP_WR;
         r_idx     <= '0;
         r_entry   <= '0;
         r_tcnt    <= '0;
         r_err     <= 1'b0;
         r_bypass  <= BypassRst;
         r_entries <= '0;
         r_wr      <= '0;
         r_rd      <= '0;
         r_cnt_err <= 1'b0;
      end else begin
         r_wr <= w_wr_nxt;
         r_rd <= w_rd_nxt;
         if (w_wr_err || w_rd_err || (r_gate && (aw_hs_i || ar_hs_i)))
            r_cnt_err <= 1'b1;
         if (w_accept) begin
            r_op    <= upd_op_i;
            r_idx   <= upd_idx_i;
            r_entry <= upd_entry_i;
            r_tcnt  <= '0;
            r_err   <= w_bad;
         end
         if (r_state == S_DRAIN) begin
            if (!w_drained && w_timeout) r_err <= 1'b1;
            else if (!w_drained) r_tcnt <= r_tcnt + 1'b1;
         end
         if (r_state == S_APPLY) begin
            case (r_op)
               OP_WR: begin
                  for (int unsigned i = 0; i < NumEntries; i++)
                     if (r_idx == IdxW'(i))
                        r_entries[i*EntryWidth +: EntryWidth] <= r_entry;
               end
               OP_SET:  r_bypass <= 1'b1;
               OP_CLR:  r_bypass <= 1'b0;
               default: ;
            endcase
         end
         if ((r_state == S_RESP) && done_ready_i) r_err <= 1'b0;
      end
   end

   assign upd_ready_o   = (r_state == S_IDLE);
   assign done_valid_o  = (r_state == S_RESP);
   assign done_err_o    = r_err;
   assign gate_o        = r_gate;
   assign entries_o     = r_entries;
   assign bypass_o      = r_bypass;
   assign inflight_wr_o = r_wr;
   assign inflight_rd_o = r_rd;
   assign cnt_err_o     = r_cnt_err;

endmodule
